// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds the scoreboard entry layout, the forwarding-select encoding and the
// default register index width. Imported by pipe_fwd_match and pipe_hazard_unit.
package pipe_pkg;

  localparam int REG_IDX_W_DEFAULT = 4;
  // rd is stored zero-extended to this width so one entry type serves every
  // REG_INDEX_BIT_WIDTH up to this limit.
  localparam int REG_IDX_W_MAX     = 8;

  localparam int FWD_REGFILE    = 0;  // operand comes from the register file
  localparam int FWD_STAGE_BASE = 1;  // select value for stage 1 (EX)

  typedef struct packed {
    logic                     valid;
    logic [REG_IDX_W_MAX-1:0] rd;
    logic                     wr;
    logic                     ld;
  } sb_entry_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Youngest-writer priority search for one source operand (purely combinational).
// Ports: sb = scoreboard, index 1 = EX (youngest); rs = zero-extended source reg;
//        sel = stage of youngest matching writer, found = any match, ld = its ld bit.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int FWD_W      = 2
) (
  input  sb_entry_t [NUM_STAGES:1]  sb,
  input  logic [REG_IDX_W_MAX-1:0]  rs,
  output logic [FWD_W-1:0]          sel,
  output logic                      found,
  output logic                      ld
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel   = FWD_W'(FWD_REGFILE);
    found = 1'b0;
    ld    = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (sb[k].valid && sb[k].wr && (sb[k].rd == rs)) begin
        sel   = FWD_W'(k - 1 + FWD_STAGE_BASE);
        found = 1'b1;
        ld    = sb[k].ld;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: scoreboard of in-flight writers (stage 1 = EX,
// stage NUM_STAGES = writeback) driving forwarding selects, load-use stall and flush.
// Ports: dec_* = decode-stage instruction, br_taken = EX branch resolved taken;
//        stall/flush/fwd_sel1/fwd_sel2/busy are combinational outputs (zero latency).
// Optional PIPE_HAZARD_PERF_EN adds clr_cnt, stall_cnt, flush_cnt (saturating counters).
// LOAD_STAGE must lie in 1..NUM_STAGES.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = REG_IDX_W_DEFAULT,
  parameter int NUM_STAGES          = 3,
  parameter int LOAD_STAGE          = 2,
  parameter int FWD_W               = $clog2(NUM_STAGES + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs2,
  input  logic                           dec_use_rs1,
  input  logic                           dec_use_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rd,
  input  logic                           dec_wr_reg,
  input  logic                           dec_is_load,
  input  logic                           br_taken,
  output logic                           stall,
  output logic                           flush,
  output logic [FWD_W-1:0]               fwd_sel1,
  output logic [FWD_W-1:0]               fwd_sel2,
  output logic                           busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  input  logic                           clr_cnt,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    flush_cnt
`endif
);

  sb_entry_t [NUM_STAGES:1] sb_q, sb_d;

  logic [FWD_W-1:0] sel1, sel2;
  logic             found1, found2, ld1, ld2;
  logic             haz1, haz2, issue;

  pipe_fwd_match #(.NUM_STAGES(NUM_STAGES), .FWD_W(FWD_W)) u_match_rs1 (
    .sb    (sb_q),
    .rs    (REG_IDX_W_MAX'(dec_rs1)),
    .sel   (sel1),
    .found (found1),
    .ld    (ld1)
  );

  pipe_fwd_match #(.NUM_STAGES(NUM_STAGES), .FWD_W(FWD_W)) u_match_rs2 (
    .sb    (sb_q),
    .rs    (REG_IDX_W_MAX'(dec_rs2)),
    .sel   (sel2),
    .found (found2),
    .ld    (ld2)
  );

  // A load whose data is not yet on a forwarding path (stage < LOAD_STAGE)
  // cannot feed the consumer; an operand the instruction does not read
  // never causes a hazard.
  assign haz1 = dec_use_rs1 & found1 & ld1 & (int'(sel1) < LOAD_STAGE);
  assign haz2 = dec_use_rs2 & found2 & ld2 & (int'(sel2) < LOAD_STAGE);

  // Flush dominates: the decode instruction dies anyway, so holding it is pointless.
  assign flush = br_taken;
  assign stall = dec_valid & ~flush & (haz1 | haz2);
  assign issue = dec_valid & ~stall & ~flush;

  assign fwd_sel1 = (dec_use_rs1 && found1) ? sel1 : FWD_W'(FWD_REGFILE);
  assign fwd_sel2 = (dec_use_rs2 && found2) ? sel2 : FWD_W'(FWD_REGFILE);

  always_comb begin
    sb_d = '0;
    busy = 1'b0;
    if (issue) begin
      sb_d[1].valid = 1'b1;
      sb_d[1].rd    = REG_IDX_W_MAX'(dec_rd);
      sb_d[1].wr    = dec_wr_reg;
      sb_d[1].ld    = dec_is_load;
    end
    for (int k = 2; k <= NUM_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    for (int k = 1; k <= NUM_STAGES; k++) begin
      busy = busy | sb_q[k].valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a driver issues one decode slot per cycle and pushes
// the reference model's expected outputs into a queue; a monitor pops and compares
// on every falling edge. The model tracks in-flight instructions as a plain queue.
module tb_pipe_hazard_unit;

  localparam int RW = 4;
  localparam int NS = 3;
  localparam int LS = 2;
  localparam int FW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_reg, dec_is_load, br_taken;
  logic [RW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          stall, flush, busy;
  logic [FW-1:0] fwd_sel1, fwd_sel2;
`ifdef PIPE_HAZARD_PERF_EN
  logic          clr_cnt;
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_INDEX_BIT_WIDTH(RW), .NUM_STAGES(NS), .LOAD_STAGE(LS)) dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_wr_reg(dec_wr_reg),
    .dec_is_load(dec_is_load), .br_taken(br_taken), .stall(stall), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy(busy)
`ifdef PIPE_HAZARD_PERF_EN
    , .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct { bit v; int rd; bit wr; bit ld; } slot_t;
  typedef struct { bit stall; bit flush; bit busy; int sel1; int sel2; } exp_t;

  slot_t pipe[$];      // pipe[0] = instruction in EX, pipe[NS-1] = writeback
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    m_stall, m_flush;
  int    m_stall_cnt, m_flush_cnt;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic clear_model();
    slot_t b;
    b = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    pipe.delete();
    for (int i = 0; i < NS; i++) pipe.push_back(b);
    m_stall = 1'b0;
    m_flush = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Stage number (1 = EX) of the nearest in-flight writer of rs, 0 if none.
  function automatic int youngest(input int rs);
    for (int i = 0; i < pipe.size(); i++)
      if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   k1, k2;
    bit   h1, h2;
    k1 = youngest(int'(dec_rs1));
    k2 = youngest(int'(dec_rs2));
    h1 = dec_use_rs1 && k1 > 0 && pipe[k1-1].ld && k1 < LS;
    h2 = dec_use_rs2 && k2 > 0 && pipe[k2-1].ld && k2 < LS;
    e.flush = br_taken;
    e.stall = dec_valid && !br_taken && (h1 || h2);
    e.sel1  = dec_use_rs1 ? k1 : 0;
    e.sel2  = dec_use_rs2 ? k2 : 0;
    e.busy  = 1'b0;
    foreach (pipe[i]) if (pipe[i].v) e.busy = 1'b1;
    m_stall = e.stall;
    m_flush = e.flush;
    return e;
  endfunction

  // Model update for the clock edge that has just happened.
  task automatic advance();
    slot_t s;
    if (!reset_n) begin
      clear_model();
      return;
    end
`ifdef PIPE_HAZARD_PERF_EN
    if (clr_cnt) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      m_stall_cnt += int'(m_stall);
      m_flush_cnt += int'(m_flush);
    end
`endif
    s = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    if (dec_valid && !m_stall && !m_flush)
      s = '{v: 1'b1, rd: int'(dec_rd), wr: dec_wr_reg, ld: dec_is_load};
    pipe.push_front(s);
    void'(pipe.pop_back());
  endtask

  task automatic step(input bit rst, input bit v, input int rs1, input int rs2,
                      input bit u1, input bit u2, input int rd, input bit wr,
                      input bit ld, input bit br);
    @(posedge clk);
    advance();
    #1;
    reset_n     = rst;
    dec_valid   = v;
    dec_rs1     = RW'(rs1);
    dec_rs2     = RW'(rs2);
    dec_use_rs1 = u1;
    dec_use_rs2 = u2;
    dec_rd      = RW'(rd);
    dec_wr_reg  = wr;
    dec_is_load = ld;
    br_taken    = br;
    if (!rst) clear_model();
    exp_q.push_back(predict());
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", int'(stall), int'(e.stall));
        chk("flush", int'(flush), int'(e.flush));
        chk("busy", int'(busy), int'(e.busy));
        if (!e.stall) begin
          chk("fwd_sel1", int'(fwd_sel1), e.sel1);
          chk("fwd_sel2", int'(fwd_sel2), e.sel2);
        end
      end
    end
  end

  initial begin
    bit r_v, r_u1, r_u2, r_wr, r_ld;
    int r_rs1, r_rs2, r_rd;
    reset_n = 1'b0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    dec_rd = '0; dec_wr_reg = 1'b0; dec_is_load = 1'b0; br_taken = 1'b0;
`ifdef PIPE_HAZARD_PERF_EN
    clr_cnt = 1'b0;
`endif
    clear_model();

    // Reset state
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU back-to-back: r3 <= r1+r2, then consumers at distance 1, 2, 3
    step(1, 1, 1, 2, 1, 1, 3, 1, 0, 0);
    step(1, 1, 3, 5, 1, 1, 4, 1, 0, 0);
    step(1, 1, 3, 9, 1, 0, 8, 1, 0, 0);
    step(1, 1, 10, 3, 0, 1, 9, 1, 0, 0);

    // Load-use: load r6, consumer held one cycle, then forwarded from stage 2
    step(1, 1, 0, 0, 0, 0, 6, 1, 1, 0);
    step(1, 1, 1, 6, 1, 1, 11, 1, 0, 0);
    step(1, 1, 1, 6, 1, 1, 11, 1, 0, 0);

    // Youngest wins: r7 written in stages 1 and 3
    step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 12, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
    step(1, 1, 7, 0, 1, 0, 13, 1, 0, 0);

    // Flush beats a simultaneous load-use hazard
    step(1, 1, 0, 0, 0, 0, 6, 1, 1, 0);
    step(1, 1, 6, 0, 1, 0, 14, 1, 0, 1);
    step(1, 1, 6, 0, 1, 0, 14, 1, 0, 0);

    // Async reset with three writers in flight
    step(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(0, 1, 3, 0, 1, 0, 5, 1, 0, 0);
    step(0, 1, 3, 0, 1, 0, 5, 1, 0, 0);
    step(1, 1, 3, 0, 1, 0, 5, 1, 0, 0);

    // Randomized traffic; a stalled decode slot is held as the front end would
    r_v = 0; r_u1 = 0; r_u2 = 0; r_wr = 0; r_ld = 0; r_rs1 = 0; r_rs2 = 0; r_rd = 0;
    for (int n = 0; n < 500; n++) begin
      if (!m_stall) begin
        r_v   = ($urandom_range(0, 9) < 8);
        r_rs1 = $urandom_range(0, 7);
        r_rs2 = $urandom_range(0, 7);
        r_u1  = ($urandom_range(0, 3) != 0);
        r_u2  = ($urandom_range(0, 1) != 0);
        r_rd  = $urandom_range(0, 7);
        r_wr  = ($urandom_range(0, 4) != 0);
        r_ld  = ($urandom_range(0, 2) == 0);
      end
      step(1, r_v, r_rs1, r_rs2, r_u1, r_u2, r_rd, r_wr, r_ld, ($urandom_range(0, 11) == 0));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef PIPE_HAZARD_PERF_EN
    @(posedge clk);
    advance();
    #1;
    chk("stall_cnt", int'(stall_cnt), m_stall_cnt);
    chk("flush_cnt", int'(flush_cnt), m_flush_cnt);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("stall_cnt_clr", int'(stall_cnt), 0);
    chk("flush_cnt_clr", int'(flush_cnt), 0);
`endif

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
